// File: rtl/sccb_reg_init.sv
// Camera register-load sequencer: walks a fixed (register, value) table and issues one SCCB write per entry.
// Optional per-entry retry on NACK/timeout is enabled by defining SCCB_INIT_RETRY_EN.
module sccb_reg_init #(
  parameter int NUM_REGS       = 6,
  parameter int DELAY_CYCLES   = 50000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        drv_wr_en,
  output logic [7:0]  drv_addr,
  output logic [7:0]  drv_wr_data,
  input  logic        drv_done,
  input  logic        drv_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index,
  output logic [31:0] debug_out
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'h0, S_FETCH = 4'h1, S_ISSUE = 4'h2, S_GAP  = 4'h3,
    S_WAIT  = 4'h4, S_CHECK = 4'h5, S_DELAY = 4'h6, S_NEXT = 4'h7,
    S_FAIL  = 4'h8, S_DONE  = 4'h9, S_ERR   = 4'hA
  } state_t;

`ifdef SCCB_INIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS);
  localparam logic [31:0] DLY_LOAD = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  // Register FF marks a delay entry; its value byte is ignored.
  function automatic logic [15:0] table_entry(input logic [7:0] i);
    case (i)
      8'd0:    return 16'h1280;
      8'd1:    return 16'hFF00;
      8'd2:    return 16'h1214;
      8'd3:    return 16'h40D0;
      8'd4:    return 16'h1101;
      8'd5:    return 16'h3A04;
      default: return 16'h0000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] dly_q, dly_d;
  logic [7:0]  err_index_q, err_index_d;
  logic        wr_en_q, wr_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] entry;
  logic        retry_ok;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    dly_d       = dly_q;
    err_index_d = err_index_q;
    entry       = table_entry(idx_q);
    retry_ok    = RETRY_EN && ({28'd0, retry_q} < 32'(MAX_RETRY));

    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          addr_d = entry[15:8];
          data_d = entry[7:0];
          if (entry[15:8] == 8'hFF) begin
            dly_d   = DLY_LOAD;
            state_d = S_DELAY;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_GAP;
      end
      S_GAP:   state_d = S_WAIT;
      S_WAIT: begin
        if (drv_done) begin
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          state_d = retry_ok ? S_ISSUE : S_FAIL;
          if (retry_ok) retry_d = retry_q + 4'd1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_CHECK: begin
        if (drv_ack) begin
          state_d = S_NEXT;
        end else begin
          state_d = retry_ok ? S_ISSUE : S_FAIL;
          if (retry_ok) retry_d = retry_q + 4'd1;
        end
      end
      // Counter runs D-1..0 and then one wrapped cycle, giving D+1 cycles here.
      S_DELAY: begin
        dly_d = dly_q - 32'd1;
        if (dly_q == '1) state_d = S_NEXT;
      end
      S_NEXT: begin
        idx_d   = idx_q + 8'd1;
        retry_d = '0;
        state_d = S_FETCH;
      end
      S_FAIL: begin
        err_index_d = idx_q;
        state_d     = S_ERR;
      end
      S_DONE, S_ERR: state_d = state_q;
      default:       state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    wr_en_d = (state_d == S_ISSUE);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
    busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERR});
  end

  // NOTE: sequential state uses non-blocking assignments only; all flops reset, none are memories.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      dly_q       <= '0;
      err_index_q <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      dly_q       <= dly_d;
      err_index_q <= err_index_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign drv_wr_en   = wr_en_q;
  assign drv_addr    = addr_q;
  assign drv_wr_data = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_index   = err_index_q;
  assign debug_out   = {state_q, retry_q, idx_q, addr_q, data_q};

endmodule
